debounce_multi: RTL and testbench
=================================

Name: debounce_multi

Overview:
Parametrised multi-channel debouncer for push-buttons and mechanical switches. It sits between raw board pins and the control logic. Each channel synchronises its raw pin, then filters both edges symmetrically using a shared tick prescaler, so long debounce times need only narrow counters. Per channel it reports a debounced active-high level plus one-clock press and release pulses.

Parameters:
WIDTH, 6, number of independent channels
POLARITY, "LOW", active level of raw pins ("HIGH" or "LOW"); outputs are always active-high
TICK_DIV, 1000, clk cycles per debounce tick (>=1; 1 = tick every clk)
TIMEOUT, 50, consecutive ticks a new level must persist before it is accepted (>=1)
HOLD_TICKS, 2000, ticks of continuous press before hold asserts (used only with DEBOUNCE_HOLD_EN)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
data_in  in  WIDTH  raw asynchronous pins
data_out  out  WIDTH  debounced state, 1 = pressed/active
press_pulse  out  WIDTH  one-clk pulse when data_out rises
release_pulse  out  WIDTH  one-clk pulse when data_out falls
hold  out  WIDTH  long-press flag (constant 0 without DEBOUNCE_HOLD_EN)

Behaviour:
- Reset: reset is asynchronous, active-low, on reset_n; clock is clk. During reset:
  - data_out, press_pulse, release_pulse and hold are 0.
  - Both synchroniser flops per channel are loaded with the inactive pin level (1 for "LOW", 0 for "HIGH").
  - All channel counters, the prescaler and the hold counters are 0.
- Synchroniser: a 2-flop chain per channel produces sample[i]. Convert to active-high as act[i] = (POLARITY=="LOW") ? ~sample[i] : sample[i].
- Prescaler: a shared free-running counter from 0 to TICK_DIV-1. tick is high on the cycle the count equals TICK_DIV-1, after which it wraps to 0. With TICK_DIV=1, tick is constantly 1.
- Per-channel counter cnt: width $clog2(TIMEOUT+1). Each clk:
  - If act==data_out: cnt<=0. A glitch clears the count on any cycle, tick or not.
  - Else if tick and cnt==TIMEOUT-1: data_out<=act, cnt<=0. Also pulse press_pulse if act=1, or release_pulse if act=0.
  - Else if tick: cnt<=cnt+1.
  - Else: hold cnt.
- Counter range: cnt never exceeds TIMEOUT-1, so there is no wrap-around.
- Pulses: registered and high for exactly the one clk in which data_out first shows its new value.
- Latency, TICK_DIV=1: a pin level held stable from cycle 0 reaches sample at cycle 2, and data_out changes at cycle 2+TIMEOUT.
- Latency, general case: between 2+(TIMEOUT-1)*TICK_DIV+1 and 2+TIMEOUT*TICK_DIV clks.
- Channels are fully independent; simultaneous events on different channels are each handled in the same cycle.
- Reset mid-operation: all state returns to the reset values, and no pulse is generated on reset entry or exit.

Optional Feature:
DEBOUNCE_HOLD_EN
- Defined:
  - Each channel gets a hold counter of width $clog2(HOLD_TICKS+1).
  - While data_out==1, the counter increments on each tick, saturating at HOLD_TICKS.
  - hold asserts (registered) once the counter reaches HOLD_TICKS and stays high while data_out==1.
  - When data_out falls, the counter and hold clear on the same cycle as release_pulse.
- Undefined: hold is tied to 0 and no hold counters are instantiated.

Decomposition:
- Package debounce_pkg:
  - POLARITY encoding constants.
  - A clog2-based width function.
  - Default TIMEOUT, TICK_DIV and HOLD_TICKS constants, shared with other input-conditioning blocks.
- Sub-module debounce_channel: synchroniser, cnt, data_out, pulse flops and the optional hold counter for one channel.
  - Instantiated WIDTH times under generate.
  - tick is an input, since the prescaler is shared in the top level.

Test Plan:
All scenarios use WIDTH=4, POLARITY="LOW", TICK_DIV=1, TIMEOUT=4 unless stated.
1. Reset: assert reset_n=0 with data_in=4'b0000 -> all outputs 0. Release with data_in=4'hF -> outputs stay 0, no pulses.
2. Clean press: data_in[0] 1->0 at cycle 0 and held -> data_out[0]=1 from cycle 6, press_pulse[0]=1 only at cycle 6; other channels unchanged.
3. Bounce: data_in[1] low for 3 cycles, high for 1, then low and held -> the counter restarts, data_out[1] rises 6 cycles after the final falling edge, with one press_pulse only.
4. Release with prescaler: TICK_DIV=5, TIMEOUT=3, channel pressed, then data_in[2] 0->1 held -> release_pulse[2] appears 13 to 17 clks later; a 4-clk high glitch mid-count produces no change.
5. Simultaneous: channels 0 and 3 change in the same cycle in opposite directions -> press_pulse[0] and release_pulse[3] on the same clk.
6. Hold (DEBOUNCE_HOLD_EN, HOLD_TICKS=10): keep channel 0 pressed -> hold[0] rises 10 ticks after data_out[0]. Then release -> hold[0] falls with release_pulse[0]. Reset mid-hold -> hold[0]=0 immediately.

Source files
------------

// File: rtl/debounce_pkg.sv
// debounce_pkg: constants and helpers shared by the input-conditioning blocks
// (pin polarity encoding, counter sizing, default debounce timing).
package debounce_pkg;

    // Text values accepted by the POLARITY parameter of the top level.
    localparam string POLARITY_LOW  = "LOW";
    localparam string POLARITY_HIGH = "HIGH";

    // Decoded pin polarity handed down to the per-channel logic.
    typedef enum logic {
        ACTIVE_LOW  = 1'b0,
        ACTIVE_HIGH = 1'b1
    } polarity_e;

    // Defaults shared with the other input-conditioning blocks.
    localparam int DEFAULT_TICK_DIV   = 1000;
    localparam int DEFAULT_TIMEOUT    = 50;
    localparam int DEFAULT_HOLD_TICKS = 2000;

    // Bits needed for a counter that must reach max_val (never less than 1).
    function automatic int count_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one debounced input. Synchronises the raw pin, filters
// both edges against a shared tick, and produces level / press / release
// flags. With DEBOUNCE_HOLD_EN defined it also drives a long-press flag.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter polarity_e POL        = ACTIVE_LOW,
    parameter int        TIMEOUT    = DEFAULT_TIMEOUT,
    parameter int        HOLD_TICKS = DEFAULT_HOLD_TICKS
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick_i,
    input  logic pin_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic hold_o
);

    localparam int            CW       = count_width(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    // Raw level of an untouched pin; the synchroniser starts here so that
    // leaving reset never looks like an edge.
    localparam logic          IDLE_PIN = (POL == ACTIVE_LOW) ? 1'b1 : 1'b0;

    logic          sync1_q, sync2_q;
    logic          act;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;

    // Two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: clocked state uses non-blocking (<=) so every flop samples
        // the pre-edge value of the others, exactly like the hardware.
        if (!reset_n) begin
            sync1_q <= IDLE_PIN;
            sync2_q <= IDLE_PIN;
        end else begin
            sync1_q <= pin_i;
            sync2_q <= sync1_q;
        end
    end

    assign act = (POL == ACTIVE_LOW) ? ~sync2_q : sync2_q;

    // Filter: any agreement clears the run; TIMEOUT ticks of disagreement flip the level.
    always_comb begin
        // NOTE: every variable gets a default first, so no path can leave
        // one unassigned and infer a latch.
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (act == level_q) begin
            cnt_d = '0;
        end else if (tick_i) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d     = '0;
                level_d   = act;
                press_d   = act;
                release_d = ~act;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    // Filter state and registered edge pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

`ifdef DEBOUNCE_HOLD_EN
    localparam int            HW       = count_width(HOLD_TICKS);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS);
    localparam logic [HW-1:0] HOLD_ONE = HW'(1);

    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          hold_q, hold_d;

    // Long-press timer: counts ticks while pressed, saturates, clears with the release.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (!level_d) begin
            hold_cnt_d = '0;
        end else if (level_q && tick_i && (hold_cnt_q != HOLD_MAX)) begin
            hold_cnt_d = hold_cnt_q + HOLD_ONE;
        end
        hold_d = (hold_cnt_d == HOLD_MAX);
    end

    // Long-press timer registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt_q <= '0;
            hold_q     <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            hold_q     <= hold_d;
        end
    end

    assign hold_o = hold_q;
`else
    assign hold_o = 1'b0;
`endif

endmodule

// File: rtl/debounce_multi.sv
// debounce_multi: WIDTH independent push-button/switch debouncers sharing one
// tick prescaler. Outputs are active-high whatever the pin polarity.
// Optional long-press detection is built when DEBOUNCE_HOLD_EN is defined.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int    WIDTH      = 6,
    parameter string POLARITY   = POLARITY_LOW,
    parameter int    TICK_DIV   = DEFAULT_TICK_DIV,
    parameter int    TIMEOUT    = DEFAULT_TIMEOUT,
    parameter int    HOLD_TICKS = DEFAULT_HOLD_TICKS
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] press_pulse,
    output logic [WIDTH-1:0] release_pulse,
    output logic [WIDTH-1:0] hold
);

    localparam polarity_e POL = (POLARITY == POLARITY_HIGH) ? ACTIVE_HIGH : ACTIVE_LOW;

    logic tick;

    generate
        if (TICK_DIV <= 1) begin : g_no_prescale
            assign tick = 1'b1;
        end else begin : g_prescale
            localparam int            PW       = count_width(TICK_DIV - 1);
            localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
            localparam logic [PW-1:0] PRE_ONE  = PW'(1);

            logic [PW-1:0] pre_q;

            assign tick = (pre_q == PRE_LAST);

            // Free-running prescaler: 0 .. TICK_DIV-1, tick on the last count.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    pre_q <= '0;
                end else begin
                    pre_q <= tick ? '0 : (pre_q + PRE_ONE);
                end
            end
        end
    endgenerate

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        debounce_channel #(
            .POL        (POL),
            .TIMEOUT    (TIMEOUT),
            .HOLD_TICKS (HOLD_TICKS)
        ) u_ch (
            .clk       (clk),
            .reset_n   (reset_n),
            .tick_i    (tick),
            .pin_i     (data_in[i]),
            .level_o   (data_out[i]),
            .press_o   (press_pulse[i]),
            .release_o (release_pulse[i]),
            .hold_o    (hold[i])
        );
    end

endmodule

// File: tb/tb_debounce_multi.sv
// tb_debounce_multi: directed scenarios plus a randomized run against a
// tick-counting reference model. Two instances: A (TICK_DIV=1, TIMEOUT=4)
// and B (TICK_DIV=5, TIMEOUT=3), both 4 channels, active-low pins.
module tb_debounce_multi;

    localparam int W    = 4;
    localparam int TD_A = 1;
    localparam int TO_A = 4;
    localparam int TD_B = 5;
    localparam int TO_B = 3;
    localparam int HT   = 10;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] din_a, dout_a, pp_a, rp_a, hd_a;
    logic [W-1:0] din_b, dout_b, pp_b, rp_b, hd_b;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    debounce_multi #(
        .WIDTH(W), .POLARITY("LOW"), .TICK_DIV(TD_A), .TIMEOUT(TO_A), .HOLD_TICKS(HT)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .data_in(din_a), .data_out(dout_a),
        .press_pulse(pp_a), .release_pulse(rp_a), .hold(hd_a)
    );

    debounce_multi #(
        .WIDTH(W), .POLARITY("LOW"), .TICK_DIV(TD_B), .TIMEOUT(TO_B), .HOLD_TICKS(HT)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .data_in(din_b), .data_out(dout_b),
        .press_pulse(pp_b), .release_pulse(rp_b), .hold(hd_b)
    );

    // ------------------------------------------------------------------
    // Reference model. Time is the index e of clock edges since reset
    // release; edge e carries a tick when e % td == td-1. A channel flips
    // once the active level has disagreed with the output continuously
    // over a span of edges containing TIMEOUT ticks.
    // ------------------------------------------------------------------
    typedef struct {
        logic s1, s2;
        logic out, press, rel, hold;
        bit   active;
        int   start;
        int   rise;
    } ch_t;

    ch_t ma [W];
    ch_t mb [W];
    int  edge_n;

    function automatic int ticks_in(input int a, input int b, input int td);
        return (b + 1) / td - a / td;
    endfunction

    function automatic ch_t ch_reset();
        ch_t c;
        c.s1 = 1'b1; c.s2 = 1'b1;
        c.out = 1'b0; c.press = 1'b0; c.rel = 1'b0; c.hold = 1'b0;
        c.active = 1'b0; c.start = 0; c.rise = 0;
        return c;
    endfunction

    function automatic ch_t ch_step(input ch_t c, input logic pin, input int e,
                                    input int td, input int to);
        ch_t  n;
        logic act;
        n       = c;
        act     = ~c.s2;
        n.press = 1'b0;
        n.rel   = 1'b0;
        if (act == c.out) begin
            n.active = 1'b0;
        end else begin
            if (!c.active) begin
                n.active = 1'b1;
                n.start  = e;
            end
            if (ticks_in(n.start, e, td) >= to) begin
                n.out    = act;
                n.press  = act;
                n.rel    = ~act;
                n.active = 1'b0;
                if (act) n.rise = e;
            end
        end
`ifdef DEBOUNCE_HOLD_EN
        if (!n.out)        n.hold = 1'b0;
        else if (!n.press) n.hold = (ticks_in(n.rise + 1, e, td) >= HT);
`else
        n.hold = 1'b0;
`endif
        n.s2 = c.s1;
        n.s1 = pin;
        return n;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_n <= 0;
            for (int i = 0; i < W; i++) begin
                ma[i] <= ch_reset();
                mb[i] <= ch_reset();
            end
        end else begin
            for (int i = 0; i < W; i++) begin
                ma[i] <= ch_step(ma[i], din_a[i], edge_n, TD_A, TO_A);
                mb[i] <= ch_step(mb[i], din_b[i], edge_n, TD_B, TO_B);
            end
            edge_n <= edge_n + 1;
        end
    end

    logic [W-1:0] ea_out, ea_pp, ea_rp, ea_hd;
    logic [W-1:0] eb_out, eb_pp, eb_rp, eb_hd;

    always_comb begin
        ea_out = '0; ea_pp = '0; ea_rp = '0; ea_hd = '0;
        eb_out = '0; eb_pp = '0; eb_rp = '0; eb_hd = '0;
        for (int i = 0; i < W; i++) begin
            ea_out[i] = ma[i].out; ea_pp[i] = ma[i].press;
            ea_rp[i]  = ma[i].rel; ea_hd[i] = ma[i].hold;
            eb_out[i] = mb[i].out; eb_pp[i] = mb[i].press;
            eb_rp[i]  = mb[i].rel; eb_hd[i] = mb[i].hold;
        end
    end

    // One clock: inputs change and outputs are sampled on the falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        reset_n = 1'b0;
        din_a   = '0;
        din_b   = '0;
        repeat (3) cyc();
        n_checks++;
        if ({dout_a, pp_a, rp_a, hd_a, dout_b, pp_b, rp_b, hd_b} !== 32'h0)
            $display("FAIL reset_outputs: got %h expected 00000000",
                     {dout_a, pp_a, rp_a, hd_a, dout_b, pp_b, rp_b, hd_b});
        else n_pass++;
        din_a   = '1;
        din_b   = '1;
        reset_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            n_checks++;
            if ({dout_a, pp_a, rp_a, hd_a, dout_b, pp_b, rp_b, hd_b} !== 32'h0)
                $display("FAIL reset_exit cycle %0d: got %h expected 00000000", k,
                         {dout_a, pp_a, rp_a, hd_a, dout_b, pp_b, rp_b, hd_b});
            else n_pass++;
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_clean_press();
        logic [W-1:0] e_out, e_pp;
        din_a[0] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            e_out = (k >= 6) ? 4'b0001 : 4'b0000;
            e_pp  = (k == 6) ? 4'b0001 : 4'b0000;
            n_checks++;
            if (dout_a !== e_out || pp_a !== e_pp || rp_a !== 4'b0000)
                $display("FAIL clean_press cycle %0d: got out=%b press=%b rel=%b expected out=%b press=%b rel=0000",
                         k, dout_a, pp_a, rp_a, e_out, e_pp);
            else n_pass++;
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_bounce();
        int presses;
        presses  = 0;
        din_a[1] = 1'b0;
        repeat (3) begin
            cyc();
            if (pp_a[1]) presses++;
        end
        din_a[1] = 1'b1;
        cyc();
        if (pp_a[1]) presses++;
        din_a[1] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            if (pp_a[1]) presses++;
            n_checks++;
            if (dout_a[1] !== (k >= 6))
                $display("FAIL bounce_level cycle %0d: got %b expected %b", k, dout_a[1], (k >= 6));
            else n_pass++;
        end
        n_checks++;
        if (presses != 1) $display("FAIL bounce_press_count: got %0d expected 1", presses);
        else n_pass++;
    endtask

    // ------------------------------------------------------------------
    task automatic test_simultaneous();
        logic [W-1:0] e_out, e_pp, e_rp;
        din_a[0] = 1'b1;
        din_a[3] = 1'b0;
        repeat (10) cyc();
        n_checks++;
        if (dout_a !== 4'b1010) $display("FAIL simul_setup: got %b expected 1010", dout_a);
        else n_pass++;
        din_a[0] = 1'b0;
        din_a[3] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            e_out = (k >= 6) ? 4'b0011 : 4'b1010;
            e_pp  = (k == 6) ? 4'b0001 : 4'b0000;
            e_rp  = (k == 6) ? 4'b1000 : 4'b0000;
            n_checks++;
            if (dout_a !== e_out || pp_a !== e_pp || rp_a !== e_rp)
                $display("FAIL simultaneous cycle %0d: got out=%b press=%b rel=%b expected out=%b press=%b rel=%b",
                         k, dout_a, pp_a, rp_a, e_out, e_pp, e_rp);
            else n_pass++;
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_release_prescaled();
        int  k;
        bit  got;
        int  rels;
        // Press channel 2 of B; latency window is 13..17 clocks.
        din_b[2] = 1'b0;
        k = 0; got = 1'b0;
        while (k < 40 && !got) begin
            cyc(); k++;
            if (pp_b[2]) got = 1'b1;
        end
        n_checks++;
        if (!got || k < 13 || k > 17 || dout_b[2] !== 1'b1)
            $display("FAIL prescaled_press: got seen=%0d after %0d clks expected within 13..17", got, k);
        else n_pass++;
        repeat (3) cyc();
        din_b[2] = 1'b1;
        k = 0; got = 1'b0;
        while (k < 40 && !got) begin
            cyc(); k++;
            if (rp_b[2]) got = 1'b1;
        end
        n_checks++;
        if (!got || k < 13 || k > 17 || dout_b[2] !== 1'b0)
            $display("FAIL prescaled_release: got seen=%0d after %0d clks expected within 13..17", got, k);
        else n_pass++;
        // Press again, then a 4-clock release glitch must be filtered out.
        din_b[2] = 1'b0;
        repeat (20) cyc();
        n_checks++;
        if (dout_b[2] !== 1'b1) $display("FAIL glitch_setup: got %b expected 1", dout_b[2]);
        else n_pass++;
        rels = 0;
        din_b[2] = 1'b1;
        repeat (4) begin
            cyc();
            if (rp_b[2]) rels++;
        end
        din_b[2] = 1'b0;
        repeat (30) begin
            cyc();
            if (rp_b[2] || dout_b[2] !== 1'b1) rels++;
        end
        n_checks++;
        if (rels != 0) $display("FAIL glitch_filtered: got %0d bad cycles expected 0", rels);
        else n_pass++;
    endtask

    // ------------------------------------------------------------------
    task automatic test_hold();
        din_a = '1;
        repeat (10) cyc();
`ifdef DEBOUNCE_HOLD_EN
        din_a[0] = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            n_checks++;
            if (hd_a[0] !== (k >= 16) || dout_a[0] !== (k >= 6))
                $display("FAIL hold_rise cycle %0d: got hold=%b out=%b expected hold=%b out=%b",
                         k, hd_a[0], dout_a[0], (k >= 16), (k >= 6));
            else n_pass++;
        end
        din_a[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            n_checks++;
            if (hd_a[0] !== (k < 6) || rp_a[0] !== (k == 6))
                $display("FAIL hold_fall cycle %0d: got hold=%b rel=%b expected hold=%b rel=%b",
                         k, hd_a[0], rp_a[0], (k < 6), (k == 6));
            else n_pass++;
        end
        din_a[0] = 1'b0;
        repeat (18) cyc();
        n_checks++;
        if (hd_a[0] !== 1'b1) $display("FAIL hold_before_reset: got %b expected 1", hd_a[0]);
        else n_pass++;
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (hd_a !== 4'b0000 || dout_a !== 4'b0000)
            $display("FAIL hold_reset: got hold=%b out=%b expected 0000 0000", hd_a, dout_a);
        else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        din_a   = '1;
        repeat (4) cyc();
`else
        din_a = '0;
        for (int k = 1; k <= 30; k++) begin
            cyc();
            n_checks++;
            if (hd_a !== 4'b0000 || hd_b !== 4'b0000)
                $display("FAIL hold_disabled cycle %0d: got %b %b expected 0000 0000", k, hd_a, hd_b);
            else n_pass++;
        end
        din_a = '1;
        repeat (10) cyc();
`endif
    endtask

    // ------------------------------------------------------------------
    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < W; i++) begin
                if ($urandom_range(0, 9) == 0)  din_a[i] = ~din_a[i];
                if ($urandom_range(0, 39) == 0) din_b[i] = ~din_b[i];
            end
            if (c == 1500) reset_n = 1'b0;
            if (c == 1503) reset_n = 1'b1;
            cyc();
            n_checks++;
            if ({dout_a, pp_a, rp_a, hd_a} !== {ea_out, ea_pp, ea_rp, ea_hd})
                $display("FAIL random_a cycle %0d: got out=%b press=%b rel=%b hold=%b expected out=%b press=%b rel=%b hold=%b",
                         c, dout_a, pp_a, rp_a, hd_a, ea_out, ea_pp, ea_rp, ea_hd);
            else n_pass++;
            n_checks++;
            if ({dout_b, pp_b, rp_b, hd_b} !== {eb_out, eb_pp, eb_rp, eb_hd})
                $display("FAIL random_b cycle %0d: got out=%b press=%b rel=%b hold=%b expected out=%b press=%b rel=%b hold=%b",
                         c, dout_b, pp_b, rp_b, hd_b, eb_out, eb_pp, eb_rp, eb_hd);
            else n_pass++;
        end
    endtask

    initial begin
        reset_n = 1'b0;
        din_a   = '0;
        din_b   = '0;
        @(negedge clk);
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_release_prescaled();
        test_hold();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
